// File: rtl/play_state_sequencer.sv
// Frame-rate game sequencer feeding color_mapper: play/power/dying/over/win flow,
// ghost release schedule, lives and mouth animation. Define MOUTH_ANIM_EN to build the mouth animator.
module play_state_sequencer #(
    parameter int MOUTH_PERIOD    = 8,
    parameter int REVERSAL_FRAMES = 360,
    parameter int GREEN_RELEASE   = 120,
    parameter int AQUA_RELEASE    = 240,
    parameter int RESPAWN_FRAMES  = 90
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       power_pellet,
    input  logic       ghost_hit,
    input  logic       dots_cleared,
    output logic       closePacman,
    output logic       reversal,
    output logic       red_enable,
    output logic       green_enable,
    output logic       aqua_enable,
    output logic       death,
    output logic       victory,
    output logic       freeze,
    output logic [1:0] lives,
    output logic       ghost_eaten
);
    typedef enum logic [2:0] {IDLE, PLAY, POWER, DYING, OVER, WIN} state_t;

    localparam logic [9:0] REV_LOAD  = 10'(REVERSAL_FRAMES);
    localparam logic [9:0] RESP_LOAD = 10'(RESPAWN_FRAMES);
    localparam logic [9:0] GREEN_AT  = 10'(GREEN_RELEASE);
    localparam logic [9:0] AQUA_AT   = 10'(AQUA_RELEASE);

    if (MOUTH_PERIOD < 1 || MOUTH_PERIOD > 255 || REVERSAL_FRAMES < 1 || REVERSAL_FRAMES > 1023 ||
        RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 1023) begin : g_bad_param
        $error("play_state_sequencer: parameter out of range");
    end

    state_t     state_reg, state_next;
    logic [1:0] lives_reg, lives_next;
    logic [9:0] rel_cnt_reg, rel_cnt_next;
    logic [9:0] timer_reg, timer_next;   // shared by the power window and the respawn freeze
    logic       red_reg, red_next;
    logic       green_reg, green_next;
    logic       aqua_reg, aqua_next;
    logic       eaten_reg, eaten_next;
    logic       active_next;

    always_comb begin
        state_next   = state_reg;
        lives_next   = lives_reg;
        rel_cnt_next = rel_cnt_reg;
        timer_next   = timer_reg;
        red_next     = red_reg;
        green_next   = green_reg;
        aqua_next    = aqua_reg;
        eaten_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = PLAY;
                    rel_cnt_next = '0;
                end
            end
            PLAY, POWER: begin
                if (frame_tick && rel_cnt_reg != 10'd1023) rel_cnt_next = rel_cnt_reg + 10'd1;
                if (state_reg == POWER && frame_tick) begin
                    if (timer_reg <= 10'd1) begin
                        state_next = PLAY;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg - 10'd1;
                    end
                end
                // Event priority: dots > ghost hit > pellet; loads override the decrement above.
                if (dots_cleared) begin
                    state_next = WIN;
                end else if (ghost_hit) begin
                    if (state_reg == PLAY) begin
                        state_next = DYING;
                        lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
                        timer_next = RESP_LOAD;
                    end else begin
                        eaten_next = 1'b1;
                    end
                end else if (power_pellet) begin
                    state_next = POWER;
                    timer_next = REV_LOAD;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (timer_reg <= 10'd1) begin
                        timer_next = '0;
                        if (lives_reg == 2'd0) begin
                            state_next = OVER;
                        end else begin
                            state_next   = PLAY;
                            rel_cnt_next = '0;
                            green_next   = 1'b0;
                            aqua_next    = 1'b0;
                        end
                    end else begin
                        timer_next = timer_reg - 10'd1;
                    end
                end
            end
            default: ;
        endcase

        active_next = (state_next == PLAY) || (state_next == POWER);
        if (active_next) begin
            red_next   = 1'b1;
            green_next = green_next | (rel_cnt_next >= GREEN_AT);
            aqua_next  = aqua_next | (rel_cnt_next >= AQUA_AT);
        end
        if (state_next == OVER) begin
            red_next   = 1'b0;
            green_next = 1'b0;
            aqua_next  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            lives_reg   <= 2'd3;
            rel_cnt_reg <= '0;
            timer_reg   <= '0;
            red_reg     <= 1'b0;
            green_reg   <= 1'b0;
            aqua_reg    <= 1'b0;
            eaten_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lives_reg   <= lives_next;
            rel_cnt_reg <= rel_cnt_next;
            timer_reg   <= timer_next;
            red_reg     <= red_next;
            green_reg   <= green_next;
            aqua_reg    <= aqua_next;
            eaten_reg   <= eaten_next;
        end
    end

`ifdef MOUTH_ANIM_EN
    logic [7:0] mouth_cnt_reg, mouth_cnt_next;
    logic       mouth_reg, mouth_next;
    logic [8:0] mouth_inc;

    always_comb begin
        mouth_cnt_next = mouth_cnt_reg;
        mouth_next     = mouth_reg;
        mouth_inc      = {1'b0, mouth_cnt_reg} + 9'd1;
        if (!active_next) begin
            mouth_cnt_next = '0;
            mouth_next     = 1'b0;
        end else if (frame_tick && (state_reg == PLAY || state_reg == POWER)) begin
            if (mouth_inc >= 9'(MOUTH_PERIOD)) begin
                mouth_cnt_next = '0;
                mouth_next     = ~mouth_reg;
            end else begin
                mouth_cnt_next = mouth_inc[7:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mouth_cnt_reg <= '0;
            mouth_reg     <= 1'b0;
        end else begin
            mouth_cnt_reg <= mouth_cnt_next;
            mouth_reg     <= mouth_next;
        end
    end

    assign closePacman = mouth_reg;
`else
    assign closePacman = 1'b0;
`endif

    // Screen/mode flags are pure decodes of the registered state.
    assign reversal     = (state_reg == POWER);
    assign death        = (state_reg == OVER);
    assign victory      = (state_reg == WIN);
    assign freeze       = !((state_reg == PLAY) || (state_reg == POWER));
    assign red_enable   = red_reg;
    assign green_enable = green_reg;
    assign aqua_enable  = aqua_reg;
    assign lives        = lives_reg;
    assign ghost_eaten  = eaten_reg;
endmodule

// File: tb/tb_play_state_sequencer.sv
// Directed bench for play_state_sequencer: vector table plus hand-written long sequences.
module tb_play_state_sequencer;
    logic       Clk = 1'b0;
    logic       Reset, frame_tick, start, power_pellet, ghost_hit, dots_cleared;
    logic       closePacman, reversal, red_enable, green_enable, aqua_enable;
    logic       death, victory, freeze, ghost_eaten;
    logic [1:0] lives;

`ifdef MOUTH_ANIM_EN
    localparam logic MOUTH_ON = 1'b1;
`else
    localparam logic MOUTH_ON = 1'b0;
`endif
    // {closePacman, reversal, red, green, aqua, death, victory, freeze, lives[1:0], ghost_eaten}
    localparam logic [10:0] RST_OUT = 11'b0_0_0_0_0_0_0_1_11_0;

    play_state_sequencer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
        .power_pellet(power_pellet), .ghost_hit(ghost_hit), .dots_cleared(dots_cleared),
        .closePacman(closePacman), .reversal(reversal), .red_enable(red_enable),
        .green_enable(green_enable), .aqua_enable(aqua_enable), .death(death),
        .victory(victory), .freeze(freeze), .lives(lives), .ghost_eaten(ghost_eaten)
    );

    always #5 Clk = ~Clk;

    logic [10:0] outs;
    assign outs = {closePacman, reversal, red_enable, green_enable, aqua_enable,
                   death, victory, freeze, lives, ghost_eaten};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic p, input logic g, input logic d);
        frame_tick = t; start = s; power_pellet = p; ghost_hit = g; dots_cleared = d;
        @(posedge Clk);
        #1;
        frame_tick = 0; start = 0; power_pellet = 0; ghost_hit = 0; dots_cleared = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(0, 0, 0, 0, 0);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        tick, st, pp, gh, dc;
        logic [10:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[8];

    initial begin
        Reset = 0; frame_tick = 0; start = 0; power_pellet = 0; ghost_hit = 0; dots_cleared = 0;
        vecs[0] = '{1, 0, 1, 1, 0, RST_OUT,                      "idle_ignores_events"};
        vecs[1] = '{0, 1, 0, 0, 0, 11'b0_0_1_0_0_0_0_0_11_0,     "start_to_play"};
        vecs[2] = '{0, 0, 1, 0, 0, 11'b0_1_1_0_0_0_0_0_11_0,     "pellet_to_power"};
        vecs[3] = '{0, 0, 0, 1, 0, 11'b0_1_1_0_0_0_0_0_11_1,     "power_hit_eaten"};
        vecs[4] = '{0, 0, 0, 0, 0, 11'b0_1_1_0_0_0_0_0_11_0,     "eaten_one_cycle"};
        vecs[5] = '{0, 0, 1, 1, 0, 11'b0_1_1_0_0_0_0_0_11_1,     "hit_beats_pellet"};
        vecs[6] = '{0, 0, 0, 1, 1, 11'b0_0_1_0_0_0_1_1_11_0,     "dots_beats_hit_power"};
        vecs[7] = '{1, 1, 1, 1, 0, 11'b0_0_1_0_0_0_1_1_11_0,     "win_ignores_events"};

        do_reset();
        check("reset_state", 16'(outs), 16'(RST_OUT));
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].tick, vecs[i].st, vecs[i].pp, vecs[i].gh, vecs[i].dc);
            check(vecs[i].name, 16'(outs), 16'(vecs[i].exp));
        end

        // Release schedule and mouth animation
        do_reset();
        step(0, 1, 0, 0, 0);
        check("red_first_play_cycle", 16'({red_enable, freeze}), 16'b10);
        for (int i = 1; i <= 240; i++) begin
            ticks(1);
            if (i == 7 || i == 8 || i == 15 || i == 16)
                check($sformatf("mouth_tick%0d", i), 16'(closePacman),
                      16'((i >= 8 && i < 16) ? MOUTH_ON : 1'b0));
            if (i == 119) check("green_before_120", 16'(green_enable), 16'd0);
            if (i == 120) check("green_at_120", 16'({green_enable, aqua_enable}), 16'b10);
            if (i == 239) check("aqua_before_240", 16'(aqua_enable), 16'd0);
            if (i == 240) check("aqua_at_240", 16'(aqua_enable), 16'd1);
        end

        // Power window: 360 frames, then extension by a pellet on tick 200
        step(0, 0, 1, 0, 0);
        check("power_entry", 16'({reversal, green_enable, aqua_enable}), 16'b111);
        ticks(359);
        check("power_tick359", 16'(reversal), 16'd1);
        ticks(1);
        check("power_tick360_end", 16'({reversal, freeze}), 16'b00);
        step(0, 0, 1, 0, 0);
        ticks(199);
        step(1, 0, 1, 0, 0);
        ticks(359);
        check("extend_tick559", 16'(reversal), 16'd1);
        ticks(1);
        check("extend_tick560_end", 16'(reversal), 16'd0);

        // Reset in the middle of a power window
        step(0, 0, 1, 0, 0);
        ticks(5);
        do_reset();
        check("reset_mid_power", 16'(outs), 16'(RST_OUT));

        // Three deaths to game over; release schedule restarts after each respawn
        step(0, 1, 0, 0, 0);
        ticks(120);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            check($sformatf("hit%0d_lives_freeze", k), 16'({lives, freeze}), 16'({2'(2 - k), 1'b1}));
            ticks(89);
            check($sformatf("dying%0d_tick89", k), 16'({freeze, death}), 16'b10);
            ticks(1);
            if (k < 2)
                check($sformatf("respawn%0d", k), 16'({freeze, red_enable, green_enable}), 16'b010);
        end
        check("game_over", 16'(outs), 16'(11'b0_0_0_0_0_1_0_1_00_0));
        step(1, 1, 1, 1, 1);
        check("over_ignores_events", 16'(outs), 16'(11'b0_0_0_0_0_1_0_1_00_0));

        // Dots and ghost hit together in PLAY
        do_reset();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        check("dots_beats_hit_play", 16'({victory, freeze, lives}), 16'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/play_state_sequencer.md
# play_state_sequencer

Frame-rate game sequencer that drives the mode and enable inputs of `color_mapper`: mouth animation, ghost release schedule, power-pellet reversal window, life accounting, and the death/victory screens. It sits between the game-logic event sources (collision, dot counter, pellet detect) and the color mapper. All timing is counted in video frames via a one-cycle `frame_tick` strobe.

## Interface
- `MOUTH_PERIOD`, default 8: frames per closePacman half-cycle (1..255).
- `REVERSAL_FRAMES`, default 360: length of the power window in frames (1..1023).
- `GREEN_RELEASE`, default 120: frames after round start before green ghost is enabled (0..1023).
- `AQUA_RELEASE`, default 240: frames after round start before aqua ghost is enabled (0..1023).
- `RESPAWN_FRAMES`, default 90: freeze length after losing a life (1..1023).

Ports:
- `Clk` in 1: system clock; single clock domain.
- `Reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame, already synchronous to Clk.
- `start` in 1: level/pulse; begins a game from IDLE.
- `power_pellet` in 1: one-cycle pulse, pacman ate a power pellet.
- `ghost_hit` in 1: one-cycle pulse, pacman overlaps an enabled ghost.
- `dots_cleared` in 1: level, all dots eaten.
- `closePacman` out 1: mouth-closed sprite select.
- `reversal` out 1: ghosts frightened (blue).
- `red_enable`, `green_enable`, `aqua_enable` out 1 each: ghost visible/active.
- `death` out 1: game-over screen.
- `victory` out 1: victory screen.
- `freeze` out 1: movement logic must hold positions.
- `lives` out 2: remaining lives.
- `ghost_eaten` out 1: one-cycle pulse, ghost hit during reversal (+score).

## Operation
- States: IDLE, PLAY, POWER, DYING, OVER, WIN. All outputs registered.
- Reset (any state, mid-window included): state=IDLE, lives=3, every counter=0, closePacman=0, reversal=0, all ghost enables=0, death=0, victory=0, freeze=1, ghost_eaten=0.
- IDLE: freeze=1. `start`=1 -> PLAY; release counter cleared.
- PLAY: freeze=0, red_enable=1. Release counter (10-bit, saturating at 1023) increments on frame_tick; green_enable=1 when counter >= GREEN_RELEASE, aqua_enable likewise with AQUA_RELEASE. Enables are sticky until the round restarts.
- Event priority in PLAY/POWER, same cycle: dots_cleared > ghost_hit > power_pellet.
- dots_cleared -> WIN: victory=1, freeze=1, reversal=0. Exit only by Reset.
- PLAY + ghost_hit -> lives decremented (saturating at 0), DYING, freeze=1, reversal timer cleared.
- PLAY + power_pellet -> POWER, reversal timer loaded with REVERSAL_FRAMES.
- POWER: reversal=1; timer decrements on frame_tick; timer reaching 0 -> PLAY the following cycle. power_pellet reloads the timer to REVERSAL_FRAMES (no stacking). ghost_hit -> ghost_eaten pulse one cycle, no life loss, stay POWER. Release counter keeps running.
- DYING: counter loaded RESPAWN_FRAMES, decrements on frame_tick; at 0: lives==0 -> OVER, else PLAY with release counter cleared and green/aqua enables cleared.
- OVER: death=1, freeze=1, all ghost enables=0. Exit only by Reset.
- Mouth: frame counter 8-bit; in PLAY/POWER toggles closePacman every MOUTH_PERIOD frame_ticks; frozen states hold closePacman=0 and clear counter.

## Timing
- Every output updates on the Clk edge after the causing input cycle (1-cycle latency).
- Frame-counted durations: N frame_ticks after entry, transition occurs on the edge following the Nth tick.
- Events arriving with frame_tick in the same cycle: event wins; counter load overrides decrement.
- ghost_eaten is exactly one cycle wide per ghost_hit pulse.
- Inputs outside PLAY/POWER (except start in IDLE) are ignored.

## Configuration
- `MOUTH_ANIM_EN`: defined -> mouth counter and toggle as above. Undefined -> counter not built, closePacman held 0 in all states.

## Test plan
- Reset, start, 120 frame_ticks -> green_enable rises on edge after tick 120; aqua after tick 240; red_enable=1 from first PLAY cycle.
- PLAY, power_pellet, 360 ticks -> reversal=1 for 360 frames then 0; second pellet at tick 200 extends reversal to tick 560.
- POWER, ghost_hit -> ghost_eaten=1 for one cycle, lives stays 3, state POWER.
- Three ghost_hits in PLAY with 90-tick gaps -> lives 2,1,0; after last DYING expiry death=1, enables=0, freeze=1.
- dots_cleared and ghost_hit same cycle -> victory=1, lives unchanged.
- With MOUTH_ANIM_EN, 16 ticks in PLAY -> closePacman toggles at ticks 8 and 16; Reset mid-POWER -> all outputs at reset values next cycle.
